// File: rtl/unary_pkg.sv
// Shared types and constants for blocks that consume or produce unary bitstreams.
package unary_pkg;

  localparam int UNARY_INPUT_WIDTH = 32;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DRAIN   = 2'd1,
    FULL    = 2'd2
  } unary_state_t;

  function automatic int unary_count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/unary_bound_tracker.sv
// Counts accepted unary bits and ones; exposes lower/upper bounds on the final
// count plus the post-update counts and remaining gap for the consumer's decisions.
module unary_bound_tracker
  import unary_pkg::*;
#(
  parameter int INPUT_WIDTH = UNARY_INPUT_WIDTH,
  parameter int COUNT_WIDTH = unary_count_width(INPUT_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_accept,
  input  logic                   i_bit,
  input  logic                   i_clear,
  output logic [COUNT_WIDTH-1:0] o_lower,
  output logic [COUNT_WIDTH-1:0] o_upper,
  output logic [COUNT_WIDTH-1:0] o_ones_next,
  output logic [COUNT_WIDTH-1:0] o_bit_next,
  output logic [COUNT_WIDTH-1:0] o_gap_next
);

  localparam logic [COUNT_WIDTH-1:0] FULL_COUNT = COUNT_WIDTH'(INPUT_WIDTH);

  logic [COUNT_WIDTH-1:0] r_ones_cnt;
  logic [COUNT_WIDTH-1:0] r_bit_cnt;
  logic [COUNT_WIDTH-1:0] w_ones_next;
  logic [COUNT_WIDTH-1:0] w_bit_next;

  assign w_ones_next = r_ones_cnt + COUNT_WIDTH'(i_accept & i_bit);
  assign w_bit_next  = r_bit_cnt + COUNT_WIDTH'(i_accept);

  assign o_ones_next = w_ones_next;
  assign o_bit_next  = w_bit_next;
  assign o_gap_next  = FULL_COUNT - w_bit_next;
  assign o_lower     = r_ones_cnt;
  // True value never exceeds INPUT_WIDTH, so modular arithmetic in COUNT_WIDTH is exact.
  assign o_upper     = FULL_COUNT - r_bit_cnt + r_ones_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ones_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (i_clear) begin
      r_ones_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (i_accept) begin
      r_ones_cnt <= w_ones_next;
      r_bit_cnt  <= w_bit_next;
    end
  end

endmodule

// File: rtl/unary_stream_to_binary.sv
// Serial unary-to-binary converter with held result and valid/ack handshake.
// Define UNARY_EARLY_TERMINATE_EN to issue the result once the bound gap is within EPSILON.
module unary_stream_to_binary
  import unary_pkg::*;
#(
  parameter int INPUT_WIDTH = UNARY_INPUT_WIDTH,
  parameter int COUNT_WIDTH = unary_count_width(INPUT_WIDTH),
  parameter int EPSILON     = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   a,
  input  logic                   ready,
  output logic [COUNT_WIDTH-1:0] result,
  output logic                   result_valid,
  input  logic                   result_ack,
  output logic [COUNT_WIDTH-1:0] lower_bound,
  output logic [COUNT_WIDTH-1:0] upper_bound,
  output logic                   overrun
);

`ifdef UNARY_EARLY_TERMINATE_EN
  localparam bit EARLY_EN = 1'b1;
`else
  localparam bit EARLY_EN = 1'b0;
`endif
  localparam int EPS_EFF     = EARLY_EN ? EPSILON : 0;
  localparam int EPS_CLAMPED = (EPS_EFF < 0) ? 0 :
                               ((EPS_EFF > INPUT_WIDTH) ? INPUT_WIDTH : EPS_EFF);
  localparam logic [COUNT_WIDTH-1:0] EPS_LIM    = COUNT_WIDTH'(EPS_CLAMPED);
  localparam logic [COUNT_WIDTH-1:0] FULL_COUNT = COUNT_WIDTH'(INPUT_WIDTH);

  unary_state_t           r_state, w_state_next;
  logic [COUNT_WIDTH-1:0] r_result, w_result_next;
  logic                   r_result_valid, w_result_valid_next;
  logic                   r_overrun, w_overrun_next;

  logic                   w_accept;
  logic                   w_clear;
  logic                   w_converged;
  logic                   w_last;
  logic [COUNT_WIDTH-1:0] w_ones_next;
  logic [COUNT_WIDTH-1:0] w_bit_next;
  logic [COUNT_WIDTH-1:0] w_gap_next;

  unary_bound_tracker #(
    .INPUT_WIDTH (INPUT_WIDTH),
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_tracker (
    .clk         (clk),
    .rst_n       (reset),
    .i_accept    (w_accept),
    .i_bit       (a),
    .i_clear     (w_clear),
    .o_lower     (lower_bound),
    .o_upper     (upper_bound),
    .o_ones_next (w_ones_next),
    .o_bit_next  (w_bit_next),
    .o_gap_next  (w_gap_next)
  );

  assign w_accept    = ready && (r_state != FULL);
  assign w_converged = (w_gap_next <= EPS_LIM);
  assign w_last      = (w_bit_next == FULL_COUNT);

  always_comb begin
    w_state_next        = r_state;
    w_clear             = 1'b0;
    w_result_next       = r_result;
    w_result_valid_next = r_result_valid && !result_ack;
    w_overrun_next      = r_overrun || (ready && (r_state == FULL));
    case (r_state)
      COLLECT: begin
        if (w_accept && w_converged) begin
          // Floor of the bound midpoint; exact once every bit has arrived.
          w_result_next       = w_ones_next + (w_gap_next >> 1);
          w_result_valid_next = 1'b1;
          w_state_next        = w_last ? FULL : DRAIN;
        end
      end
      DRAIN: begin
        if (w_accept && w_last) w_state_next = FULL;
      end
      FULL: begin
        if (!r_result_valid || result_ack) begin
          w_clear      = 1'b1;
          w_state_next = COLLECT;
        end
      end
      default: w_state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= COLLECT;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_result       <= w_result_next;
      r_result_valid <= w_result_valid_next;
      r_overrun      <= w_overrun_next;
    end
  end

  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_unary_stream_to_binary.sv
// Directed bench for unary_stream_to_binary (INPUT_WIDTH=8, EPSILON=2) with a result scoreboard.
`timescale 1ns/1ps
module tb_unary_stream_to_binary;

  localparam int W   = 8;
  localparam int EPS = 2;
  localparam int CW  = 4;
`ifdef UNARY_EARLY_TERMINATE_EN
  localparam int CONV = W - EPS;
`else
  localparam int CONV = W;
`endif

  typedef logic stream_t [W];

  logic          clk = 1'b0;
  logic          reset;
  logic          a;
  logic          ready;
  logic          result_ack;
  logic [CW-1:0] result;
  logic          result_valid;
  logic [CW-1:0] lower_bound;
  logic [CW-1:0] upper_bound;
  logic          overrun;

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];
  logic prev_valid = 1'b0;

  always #5 clk = ~clk;

  unary_stream_to_binary #(
    .INPUT_WIDTH (W),
    .COUNT_WIDTH (CW),
    .EPSILON     (EPS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .a            (a),
    .ready        (ready),
    .result       (result),
    .result_valid (result_valid),
    .result_ack   (result_ack),
    .lower_bound  (lower_bound),
    .upper_bound  (upper_bound),
    .overrun      (overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Ones among the bits seen at issue time plus half the outstanding gap.
  function automatic int model_result(input stream_t s);
    int r = 0;
    for (int k = 0; k < CONV; k++) r += int'(s[k]);
    return r + (W - CONV) / 2;
  endfunction

  // Scoreboard consumer: every rising result_valid pops one expected value.
  always @(negedge clk) begin
    if (reset && result_valid && !prev_valid) begin
      int e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      $display("txn result=%0d expected=%0d t=%0t", result, e, $time);
      check("result", {28'd0, result}, e);
    end
    prev_valid <= result_valid;
  end

  task automatic drive(input logic b, input logic rdy, input logic ack);
    a = b;
    ready = rdy;
    result_ack = ack;
    @(negedge clk);
  endtask

  task automatic send_value(input stream_t s, input int spacing, input bit ack_last);
    int ones = 0;
    exp_q.push_back(model_result(s));
    for (int k = 1; k <= W; k++) begin
      for (int g = 1; g < spacing; g++) begin
        drive(1'b1, 1'b0, 1'b0);
        check("lower_idle", lower_bound, ones);
        check("upper_idle", upper_bound, W - k + 1 + ones);
      end
      ones += int'(s[k-1]);
      drive(s[k-1], 1'b1, ack_last && (k == W));
      check("lower", lower_bound, ones);
      check("upper", upper_bound, W - k + ones);
      check("valid", result_valid, (k >= CONV) && !(ack_last && (k == W) && (W - 1 >= CONV)));
    end
  endtask

  task automatic finish_value();
    if (result_valid) begin
      drive(1'b0, 1'b0, 1'b1);
      check("valid_after_ack", result_valid, 0);
    end
    drive(1'b0, 1'b0, 1'b0);
    check("lower_cleared", lower_bound, 0);
    check("upper_cleared", upper_bound, W);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    stream_t s;
    reset = 1'b0;
    a = 1'b0;
    ready = 1'b0;
    result_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_result", result, 0);
    check("rst_valid", result_valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_lower", lower_bound, 0);
    check("rst_upper", upper_bound, W);
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0);

    // Mixed stream, continuous ready
    s = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    send_value(s, 1, 1'b0);
    finish_value();

    // Six ones then two zeros
    s = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    send_value(s, 1, 1'b0);
    finish_value();

    // All ones with ready every third cycle
    s = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    send_value(s, 3, 1'b0);
    finish_value();

    // Withheld ack, then an extra bit in FULL
    s = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    send_value(s, 1, 1'b0);
    check("overrun_before", overrun, 0);
    drive(1'b1, 1'b1, 1'b0);
    check("overrun_set", overrun, 1);
    check("lower_overrun", lower_bound, 4);
    check("result_held", result, model_result(s));
    check("valid_held", result_valid, 1);
    drive(1'b0, 1'b0, 1'b0);
    check("overrun_sticky", overrun, 1);
    finish_value();
    check("overrun_after_ack", overrun, 1);

    // Reset pulse after four bits
    repeat (4) drive(1'b1, 1'b1, 1'b0);
    check("lower_partial", lower_bound, 4);
    a = 1'b0;
    ready = 1'b0;
    reset = 1'b0;
    #1;
    check("mid_rst_result", result, 0);
    check("mid_rst_valid", result_valid, 0);
    check("mid_rst_overrun", overrun, 0);
    check("mid_rst_lower", lower_bound, 0);
    check("mid_rst_upper", upper_bound, W);
    @(negedge clk);
    reset = 1'b1;
    s = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    send_value(s, 1, 1'b0);
    finish_value();

    // Ack together with the final accepted bit, then a clean follow-on value
    s = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    send_value(s, 1, 1'b1);
    finish_value();
    s = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    send_value(s, 1, 1'b0);
    finish_value();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/unary_stream_to_binary.md
# unary_stream_to_binary

Downstream consumer for the unary divide stages: takes a serial unary bitstream (one bit per `ready`-qualified cycle, INPUT_WIDTH bits per value) and converts it to a binary count of ones. It tracks lower/upper bounds on the final count while bits arrive. It can issue the result before the stream ends once the bounds are within EPSILON, then drains the remaining bits. It sits directly after `valid`/`y` of a unary divide stage and presents a held binary result with a valid/ack handshake.

## Interface
- INPUT_WIDTH, 32, unary stream length per value (bits).
- COUNT_WIDTH, $clog2(INPUT_WIDTH + 1), width of counts and result.
- EPSILON, 0, maximum bound gap (upper − lower) at which an early result is issued.

- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- a  input  1  unary stream bit (connect to upstream `y`).
- ready  input  1  `a` is valid this cycle (connect to upstream `valid`).
- result  output  COUNT_WIDTH  binary value; held while result_valid.
- result_valid  output  1  result available.
- result_ack  input  1  consumer accepts result.
- lower_bound  output  COUNT_WIDTH  ones seen so far.
- upper_bound  output  COUNT_WIDTH  ones seen + bits still outstanding.
- overrun  output  1  sticky: a bit arrived while the block could not accept it.

## Operation
- Registers: ones_cnt, bit_cnt (both COUNT_WIDTH), result, result_valid, overrun, state.
- lower_bound = ones_cnt; upper_bound = INPUT_WIDTH − bit_cnt + ones_cnt (combinational from registers, computed in COUNT_WIDTH+1 bits, never exceeds INPUT_WIDTH).
- Accepted bit (ready=1 and state ≠ FULL): bit_cnt += 1, ones_cnt += a.
- States:
  - COLLECT: accept bits; on convergence latch result, set result_valid, go to DRAIN. If bit_cnt reaches INPUT_WIDTH at the same time, go to FULL.
  - DRAIN: result held; keep accepting bits until bit_cnt == INPUT_WIDTH, then go to FULL. result_ack clears result_valid but does not leave DRAIN.
  - FULL: bit_cnt == INPUT_WIDTH. Bits with ready=1 are not accepted and set overrun. Leave when result_valid is clear: either already acked, or result_ack this cycle. On leaving, clear both counters and go to COLLECT.
- Convergence evaluated on post-update counts: gap = INPUT_WIDTH − bit_cnt_next.
  - Converged when gap ≤ EPSILON (macro on) or gap == 0 (macro off).
  - result = ones_cnt_next + (gap >> 1). This is the floor of the midpoint and is exact when gap = 0.
- FULL → COLLECT with ready=1 in the same cycle: that bit is not accepted, and overrun is set. The upstream must leave one idle cycle between values.
- overrun clears only on reset.

## Timing
- Reset (asynchronous, active-low) clears all outputs:
  - result=0, result_valid=0, overrun=0, lower_bound=0, upper_bound=INPUT_WIDTH.
  - state=COLLECT.
- Reset mid-stream discards partial counts. There is no pending result after reset.
- Latency: result_valid rises on the clock edge that accepts the converging bit. It is visible the cycle after that bit is presented.
- result_ack is sampled only while result_valid=1; result_valid falls on the following edge.
- Minimum per-value period: INPUT_WIDTH accepted cycles + 1 FULL cycle (ack already given).
- The bounds update on the same edge as the counters.

## Configuration
- UNARY_EARLY_TERMINATE_EN defined:
  - Result is issued at gap ≤ EPSILON, i.e. after INPUT_WIDTH − EPSILON bits.
  - Error ≤ ceil(EPSILON/2).
- Undefined:
  - EPSILON is ignored and the result is issued only after all INPUT_WIDTH bits, exact.
  - The DRAIN state is never entered with bits outstanding: COLLECT goes directly to FULL.

## Structure
- Shared package `unary_pkg`:
  - state enum (COLLECT, DRAIN, FULL).
  - count-width helper function.
  - common INPUT_WIDTH default constant, shared with the divide stages.
- Sub-module `unary_bound_tracker`:
  - owns ones_cnt/bit_cnt, accept/clear inputs, lower/upper/gap outputs.
  - reusable by other unary consumers.
- Top module holds the FSM, result register and overrun.

## Test plan
- INPUT_WIDTH=8, macro off: stream 1,1,0,1,0,0,1,0 with ready=1 continuously → result_valid rises after 8th bit, result=4; ack → back to COLLECT after one FULL cycle.
- Macro on, EPSILON=2, stream 1,1,1,1,1,1 then 0,0 → result_valid after 6th bit with result=7 (6+1); DRAIN accepts 2 more bits; FULL; ack → COLLECT.
- Gaps in ready (ready=1 every third cycle) for stream of all ones, macro off → result=8; bounds step only on ready cycles.
- Withhold ack, then send 9th bit with ready=1 in FULL → overrun=1 and stays 1; result unchanged at held value.
- Assert reset low for one cycle mid-stream (after 4 bits) → all outputs at reset values immediately; a fresh 8-bit stream of zeros then gives result=0.
- Ack in the same cycle as the last bit is accepted (macro on, EPSILON=2) → result_valid clears; FULL lasts one cycle; next value starts cleanly.
